// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, data width and the
// even-parity helper used when the parity build option is enabled.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous show-ahead byte FIFO. The head entry is presented on dout with
// no read latency; dout reads 0 while empty.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write request and data (ignored when full unless popping)
//   pop         remove head (ignored when empty)
//   dout        head entry
//   full, empty status
//   count       number of entries held, 0..DEPTH
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] din,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic [CW-1:0]          count
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   do_push_s, do_pop_s;

    assign empty = (count_q == {CW{1'b0}});
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? {UART_DATA_W{1'b0}} : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop_s  = pop & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push_s = push & (~full | do_pop_s);
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {UART_DATA_W{1'b0}};
            end
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with show-ahead receive FIFO. Deserialises 8N1 frames
// (8E1 when UART_RX_PARITY_EN is defined), validates start/stop (and parity)
// and queues good bytes.
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   UART_RX      serial input, asynchronous, idle high
//   RX_POP       consumer takes RX_DATA this cycle
//   RX_DATA      head-of-FIFO byte (0 while empty)
//   RX_VALID     FIFO not empty
//   RX_COUNT     bytes held
//   FRAME_ERR    1-cycle pulse, stop bit sampled 0
//   OVERRUN      1-cycle pulse, good byte dropped because FIFO full
//   PARITY_ERR   1-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
// Build option: UART_RX_PARITY_EN adds the PARITY state and PARITY_ERR port.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BAUDRATE_DIVISOR = 10416,
    parameter int FIFO_DEPTH       = 8,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   UART_RX,
    input  logic                   RX_POP,
    output logic [UART_DATA_W-1:0] RX_DATA,
    output logic                   RX_VALID,
    output logic [CW-1:0]          RX_COUNT,
    output logic                   FRAME_ERR,
    output logic                   OVERRUN
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   PARITY_ERR
`endif
);

    localparam int CNT_W = $clog2(BAUDRATE_DIVISOR);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUDRATE_DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUDRATE_DIVISOR / 2 - 1);

    rx_state_e              state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic                   rx_s;
    logic                   rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   push_s;
    logic                   fifo_full_s, fifo_empty_s;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   parity_err_q, parity_err_d;
    logic                   par_bad_s;
`endif

    assign rx_s = sync_q[1];

    // Synchroniser shift and edge-detect history.
    always_comb begin
        sync_d    = {sync_q[0], UART_RX};
        rx_prev_d = rx_s;
    end

    // Receiver FSM: next state, baud counter, shifter and flag generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == BAUD_LAST) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
        par_bad_s    = (par_bit_q != even_parity(shift_q));
`endif
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                // Half a bit in: line must still be low or it was a glitch.
                if (cnt_q == HALF_LAST) begin
                    state_d = rx_s ? IDLE : DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    shift_d = {rx_s, shift_q[UART_DATA_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BAUD_LAST) begin
                    par_bit_d = rx_s;
                    state_d   = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (cnt_q == BAUD_LAST) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad_s;
                    push_s       = rx_s & ~par_bad_s;
`else
                    push_s       = rx_s;
`endif
                    frame_err_d = ~rx_s;
                    state_d     = rx_s ? IDLE : BREAK;
                end else begin
                    state_d = STOP;
                end
            end
            BREAK: begin
                // Stay here until the line is released so a held-low line flags once.
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
        overrun_d = push_s & fifo_full_s & ~RX_POP;
    end

    // Receiver state registers; synchroniser presets to idle-high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            cnt_q       <= {CNT_W{1'b0}};
            bit_q       <= 3'd0;
            shift_q     <= {UART_DATA_W{1'b0}};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rx_prev_q   <= rx_prev_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity bit capture and error pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign PARITY_ERR = parity_err_q;
`endif

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push_s),
        .pop   (RX_POP),
        .din   (shift_q),
        .dout  (RX_DATA),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (RX_COUNT)
    );

    assign RX_VALID  = ~fifo_empty_s;
    assign FRAME_ERR = frame_err_q;
    assign OVERRUN   = overrun_q;

endmodule
